// File: rtl/mem_access_unit_pkg.sv
// Shared CPU-wide definitions for the memory access unit.
// Holds the FSM state encoding, the word width and the default dcache depth.
package mem_access_unit_pkg;

   localparam int DCACHE_DEPTH = 256;
   localparam int WORD_W       = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      RESP    = 2'd2
   } mau_state_e;

   // Widened compare so a depth of 65536 still covers the full 16-bit address space.
   function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int depth);
      return {1'b0, addr} < 17'(depth);
   endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the pipeline and a synchronous-read dcache.
// Accepts one request in IDLE, waits a cycle for load data, then holds the response until taken.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DEPTH = DCACHE_DEPTH
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              dc_r_en,
   output logic              dc_w_en,
   output logic [WORD_W-1:0] dc_addr,
   output logic [WORD_W-1:0] dc_w_data,
   input  logic [WORD_W-1:0] dc_r_data
);

   mau_state_e        state;
   mau_state_e        state_next;
   logic              accept;
   logic              in_range;
   logic [WORD_W-1:0] rdata_q;
   logic              err_q;

   // Gating accept with reset keeps the dcache port quiet while reset is held.
   assign req_ready  = (state == IDLE);
   assign accept     = req_valid && req_ready && reset;
   assign in_range   = addr_in_range(req_addr, DEPTH);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_comb begin
      dc_r_en   = 1'b0;
      dc_w_en   = 1'b0;
      dc_addr   = '0;
      dc_w_data = '0;
      if (accept && in_range) begin
         dc_addr = req_addr;
         if (req_we) begin
            dc_w_en   = 1'b1;
            dc_w_data = req_wdata;
         end else begin
            dc_r_en = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (in_range && !req_we) ? LD_WAIT : RESP;
            end
         end
         LD_WAIT: state_next = RESP;
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Response payload only changes on accept or load capture, so it holds while stalled in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= '0;
         err_q   <= !in_range;
      end else if (state == LD_WAIT) begin
         rdata_q <= dc_r_data;
         err_q   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural dcache beside the DUT.
// Directed vector table, stall/reset sequences, random traffic against a word-array model.
module tb_mem_access_unit;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        dc_r_en;
   logic        dc_w_en;
   logic [15:0] dc_addr;
   logic [15:0] dc_w_data;
   logic [15:0] dc_r_data;
   logic        init_mem;

   int checks = 0;
   int errors = 0;

   logic [15:0] dc_mem  [0:DEPTH-1];
   logic [15:0] ref_mem [0:DEPTH-1];

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs [9];

   mem_access_unit #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dc_r_en    (dc_r_en),
      .dc_w_en    (dc_w_en),
      .dc_addr    (dc_addr),
      .dc_w_data  (dc_w_data),
      .dc_r_data  (dc_r_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read dcache: data appears the cycle after the read enable edge.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < DEPTH; i++) dc_mem[i] <= 16'(i);
         dc_r_data <= '0;
      end else begin
         if (dc_w_en && dc_addr < 16'(DEPTH)) dc_mem[dc_addr[7:0]] <= dc_w_data;
         if (dc_r_en) dc_r_data <= (dc_addr < 16'(DEPTH)) ? dc_mem[dc_addr[7:0]] : 16'h0000;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Protocol rules on the dcache port, sampled mid-cycle.
   always @(negedge clk) begin
      checks++;
      if ((dc_r_en && dc_w_en) ||
          ((dc_r_en || dc_w_en) && !(req_valid && req_ready && reset)) ||
          (!dc_r_en && !dc_w_en && (dc_addr != 16'h0 || dc_w_data != 16'h0))) begin
         errors++;
         $display("[TB] FAIL dc_port: r_en=%b w_en=%b addr=0x%0h wdata=0x%0h valid=%b ready=%b, expected single enable only on accept and zero bus when idle",
                  dc_r_en, dc_w_en, dc_addr, dc_w_data, req_valid, req_ready);
      end
   end

   // Called at posedge+1 with resp_ready=1; returns at posedge+1 after the response is consumed.
   task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat,
                                 input string tag);
      int wait_cyc = 0;
      int lat;
      while (!req_ready && wait_cyc < 10) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check_output({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      check_output({tag, " dc_r_en"}, 32'(dc_r_en), 32'(!we && !exp_err));
      check_output({tag, " dc_w_en"}, 32'(dc_w_en), 32'(we && !exp_err));
      check_output({tag, " dc_addr"}, 32'(dc_addr), exp_err ? 32'd0 : 32'(addr));
      check_output({tag, " dc_w_data"}, 32'(dc_w_data), (we && !exp_err) ? 32'(wdata) : 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      lat = 1;
      while (!resp_valid && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, " resp_rdata"}, 32'(resp_rdata), 32'(exp_rdata));
      check_output({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
      @(posedge clk); #1;
   endtask

   // Expected response derived from the address-range rule and the word-array model.
   task automatic model_request(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input string tag);
      logic        err;
      logic [15:0] rd;
      int          lat;
      err = (int'(addr) >= DEPTH);
      rd  = (!we && !err) ? ref_mem[addr[7:0]] : 16'h0000;
      lat = (!we && !err) ? 2 : 1;
      apply_stimulus(we, addr, wdata, rd, err, lat, tag);
      if (we && !err) ref_mem[addr[7:0]] = wdata;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int wait_cyc;
      int last_acc;
      int n_acc;
      int cyc;
      logic last_we;
      logic [15:0] a;
      logic        w;

      reset      = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 16'h0005;
      req_wdata  = 16'hFFFF;
      resp_ready = 1'b1;
      init_mem   = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(i);

      #3;
      check_output("rst req_ready", 32'(req_ready), 32'd1);
      check_output("rst resp_valid", 32'(resp_valid), 32'd0);
      check_output("rst resp_rdata", 32'(resp_rdata), 32'd0);
      check_output("rst resp_err", 32'(resp_err), 32'd0);
      check_output("rst dc_r_en", 32'(dc_r_en), 32'd0);
      check_output("rst dc_w_en", 32'(dc_w_en), 32'd0);
      check_output("rst dc_addr", 32'(dc_addr), 32'd0);
      check_output("rst dc_w_data", 32'(dc_w_data), 32'd0);

      @(posedge clk); #1;
      init_mem  = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      #1 reset = 1'b1;
      @(posedge clk); #1;

      vecs[0] = '{1'b0, 16'h0005, 16'h0000, 16'h0005, 1'b0, 2};
      vecs[1] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1};
      vecs[2] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2};
      vecs[3] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1};
      vecs[4] = '{1'b1, 16'hFFFF, 16'h1111, 16'h0000, 1'b1, 1};
      vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 2};
      vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2};
      vecs[7] = '{1'b1, 16'h00FF, 16'hA5A5, 16'h0000, 1'b0, 1};
      vecs[8] = '{1'b0, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0, 2};
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                        vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
         if (vecs[i].we && !vecs[i].exp_err) ref_mem[vecs[i].addr[7:0]] = vecs[i].wdata;
      end

      // Stalled response: payload holds and requests are ignored.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 16'h0003;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_cyc  = 0;
      while (!resp_valid && wait_cyc < 5) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         req_valid = (i % 2 == 0);
         req_we    = 1'b1;
         req_addr  = 16'h0007;
         req_wdata = 16'h1234;
         #1;
         check_output($sformatf("stall%0d resp_valid", i), 32'(resp_valid), 32'd1);
         check_output($sformatf("stall%0d resp_rdata", i), 32'(resp_rdata), 32'h0003);
         check_output($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
         check_output($sformatf("stall%0d dc_w_en", i), 32'(dc_w_en), 32'd0);
         @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check_output("stall release req_ready", 32'(req_ready), 32'd1);
      check_output("stall release resp_valid", 32'(resp_valid), 32'd0);
      model_request(1'b0, 16'h0007, 16'h0000, "stall no-write");

      // Reset pulled during LD_WAIT discards the load.
      req_valid = 1'b1;
      req_addr  = 16'h0010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = '0;
      check_output("ldwait resp_valid", 32'(resp_valid), 32'd0);
      #2 reset = 1'b0;
      #1;
      check_output("ldwait rst req_ready", 32'(req_ready), 32'd1);
      check_output("ldwait rst resp_rdata", 32'(resp_rdata), 32'd0);
      check_output("ldwait rst resp_err", 32'(resp_err), 32'd0);
      check_output("ldwait rst resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_output($sformatf("post-rst%0d resp_valid", i), 32'(resp_valid), 32'd0);
      end

      // Reset during RESP of a store: response dropped, write kept.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 16'h0020;
      req_wdata  = 16'h5555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      ref_mem[8'h20] = 16'h5555;
      check_output("resp-rst before resp_valid", 32'(resp_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_output("resp-rst resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #2;
      reset      = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      model_request(1'b0, 16'h0020, 16'h0000, "store kept");

      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom_range(0, 299));
         w = 1'($urandom_range(0, 1));
         model_request(w, a, 16'($urandom), $sformatf("rand%0d", i));
      end

      // Back-to-back requests: accept spacing follows the previous request type.
      n_acc    = 0;
      last_acc = 0;
      last_we  = 1'b0;
      cyc      = 0;
      while (n_acc < 8 && cyc < 60) begin
         req_valid = 1'b1;
         req_we    = (n_acc % 3 == 1);
         req_addr  = 16'($urandom_range(0, DEPTH - 1));
         req_wdata = 16'($urandom);
         #1;
         if (req_ready) begin
            if (n_acc > 0) begin
               check_output($sformatf("b2b gap%0d", n_acc), 32'(cyc - last_acc), last_we ? 32'd2 : 32'd3);
            end
            if (req_we) ref_mem[req_addr[7:0]] = req_wdata;
            last_acc = cyc;
            last_we  = req_we;
            n_acc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      check_output("b2b accept count", 32'(n_acc), 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit words in the downstream dcache; legal word addresses are 0..DEPTH-1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  16  word address.
REQ-008 req_wdata  input  16  store data.
REQ-009 resp_valid  output  1  response present.
REQ-010 resp_ready  input  1  pipeline accepts the response.
REQ-011 resp_rdata  output  16  load data; 0 for stores and errors.
REQ-012 resp_err  output  1  request address was out of range.
REQ-013 dc_r_en  output  1  dcache read enable.
REQ-014 dc_w_en  output  1  dcache write enable.
REQ-015 dc_addr  output  16  dcache address.
REQ-016 dc_w_data  output  16  dcache write data.
REQ-017 dc_r_data  input  16  dcache read data, valid one cycle after the dc_r_en edge.

Function
REQ-018 The unit SHALL implement the FSM states IDLE, LD_WAIT and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted in a cycle when req_valid && req_ready.
REQ-020 In-range test: req_addr < DEPTH, evaluated combinationally on the accepting cycle.
REQ-021 Accepted in-range load: dc_r_en=1 and dc_addr=req_addr combinationally in the accept cycle; next state LD_WAIT.
REQ-022 In LD_WAIT: capture dc_r_data into resp_rdata, set resp_err=0, then go to RESP; the load response is asserted 2 cycles after accept.
REQ-023 Accepted in-range store: dc_w_en=1, dc_addr=req_addr and dc_w_data=req_wdata in the accept cycle; resp_rdata=0 and resp_err=0; next state RESP; the response is asserted 1 cycle after accept.
REQ-024 Accepted out-of-range request: no dcache enable is asserted; resp_err=1 and resp_rdata=0; next state RESP.
REQ-025 dc_r_en and dc_w_en SHALL never be 1 in the same cycle, and both SHALL be 0 outside an accept cycle.
REQ-026 When dc_r_en and dc_w_en are 0, dc_addr and dc_w_data SHALL be 0.
REQ-027 resp_valid SHALL be 1 exactly in RESP.
REQ-028 resp_rdata and resp_err SHALL hold stable while resp_valid && !resp_ready.
REQ-029 RESP && resp_ready SHALL return the FSM to IDLE; a new request cannot be accepted in that same cycle, giving a minimum spacing of 2 cycles for stores and 3 cycles for loads.
REQ-030 req_valid is ignored outside IDLE; the unit SHALL buffer no requests.

Reset
REQ-031 While reset=0: state=IDLE, resp_rdata=0, resp_err=0, resp_valid=0, req_ready=1, and all dc_* outputs are 0.
REQ-032 A reset asserted in LD_WAIT or RESP SHALL discard the in-flight response; a store already written to the dcache is not undone.

Structure
REQ-033 The FSM state encoding and the DEPTH default SHALL live in a shared cpu-wide definitions package.
REQ-034 The block SHALL be self-contained with no sub-module; the dcache is instantiated beside it at the top level.

Verification
REQ-035 Load at addr 0x0005 after reset, with dcache initialised mem[i]=i and resp_ready=1: resp_valid 2 cycles after accept, resp_rdata=0x0005, resp_err=0.
REQ-036 Store 0xBEEF to 0x0010, then load 0x0010: store responds 1 cycle after accept with rdata=0; the load returns 0xBEEF.
REQ-037 Load at 0x0100 with DEPTH=256: dc_r_en stays 0; response 1 cycle after accept with resp_err=1, resp_rdata=0.
REQ-038 Load 0x0003 with resp_ready held low for 5 cycles: resp_valid, resp_rdata=0x0003 and req_ready=0 all stable; req_valid toggling causes no dcache access.
REQ-039 reset pulsed low in LD_WAIT: all outputs go to reset values immediately (asynchronous); no response appears after reset is released.
REQ-040 Back-to-back req_valid=1 with resp_ready=1: accepts occur every 2 (store) or 3 (load) cycles, and dc_r_en and dc_w_en are never asserted together.
